// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter: FSM state encoding,
// default widths and the round-robin pointer wrap.
package alu_arb_pkg;

  localparam int unsigned DefNumReq        = 4;
  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefSelWidth      = 3;
  localparam int unsigned DefTimeoutCycles = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  function automatic int unsigned wrap_next(input int unsigned ptr, input int unsigned num);
    return (ptr + 1 >= num) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin selector: first set request searching upward
// from ptr+1 with wrap, returned as one-hot grant plus binary index.
module alu_rr_picker
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = wrap_next(32'(ptr), NUM_REQ);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = IdxW'(cand);
        grant[cand] = 1'b1;
      end
      cand = wrap_next(cand, NUM_REQ);
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, one transaction in flight.
// Optional WAIT-state watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned SEL_WIDTH      = DefSelWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]    req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_2,
  input  logic [NUM_REQ-1:0]              req_parity,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0]         rsp_data,
  output logic                            rsp_err,
  output logic                            alu_valid_ip,
  input  logic                            alu_ready_ip,
  output logic [SEL_WIDTH-1:0]            alu_sel_ip,
  output logic [DATA_WIDTH-1:0]           alu_data_ip_1,
  output logic [DATA_WIDTH-1:0]           alu_data_ip_2,
  output logic                            alu_parity_ip,
  input  logic                            alu_valid_op,
  output logic                            alu_ready_op,
  input  logic [2*DATA_WIDTH-1:0]         alu_data_op,
  input  logic                            alu_err_op
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : gen_bad_num_req
    $error("NUM_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e              state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   d1_q, d1_d;
  logic [DATA_WIDTH-1:0]   d2_q, d2_d;
  logic                    par_q, par_d;
  logic                    alu_valid_q, alu_valid_d;
  logic                    alu_ready_op_q;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0] pick_grant;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] gnt_onehot;

  alu_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign gnt_onehot = NUM_REQ'(1) << gnt_q;

  // Only combinational output; masked during reset so it reads as idle.
  assign req_ready = (state_q == StIdle && rst) ? pick_grant : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    par_d       = par_q;
    alu_valid_d = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          ptr_d       = pick_idx;
          gnt_d       = pick_idx;
          sel_d       = req_sel[pick_idx*SEL_WIDTH +: SEL_WIDTH];
          d1_d        = req_data_1[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          d2_d        = req_data_2[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          par_d       = req_parity[pick_idx];
          alu_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (alu_ready_ip) begin
          state_d = StWait;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          alu_valid_d = 1'b1;
        end
      end
      StWait: begin
        if (alu_valid_op) begin
          rsp_data_d  = alu_data_op;
          rsp_err_d   = alu_err_op;
          rsp_valid_d = gnt_onehot;
          state_d     = StResp;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the ALU; any beat that shows up later is discarded as stale.
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_onehot;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready[gnt_q]) begin
          state_d = StIdle;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      ptr_q          <= IdxW'(NUM_REQ - 1);
      gnt_q          <= '0;
      sel_q          <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      par_q          <= 1'b0;
      alu_valid_q    <= 1'b0;
      alu_ready_op_q <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      sel_q          <= sel_d;
      d1_q           <= d1_d;
      d2_q           <= d2_d;
      par_q          <= par_d;
      alu_valid_q    <= alu_valid_d;
      // Always willing to take a beat; outside WAIT it is simply dropped.
      alu_ready_op_q <= 1'b1;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  assign alu_valid_ip  = alu_valid_q;
  assign alu_sel_ip    = sel_q;
  assign alu_data_ip_1 = d1_q;
  assign alu_data_ip_2 = d2_q;
  assign alu_parity_ip = par_q;
  assign alu_ready_op  = alu_ready_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: directed transactions, a bench-side ALU and
// requesters, and a monitor checking grants, ALU inputs, responses and hold behaviour.
module tb_alu_req_arbiter;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       par;
  } op_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    int unsigned dly;
  } reply_t;

  typedef struct packed {
    int unsigned idx;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*3-1:0] req_sel = '0;
  logic [NR*8-1:0] req_data_1 = '0;
  logic [NR*8-1:0] req_data_2 = '0;
  logic [NR-1:0] req_parity = '0;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready = '0;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          alu_valid_ip;
  logic          alu_ready_ip = 1'b0;
  logic [2:0]    alu_sel_ip;
  logic [7:0]    alu_data_ip_1;
  logic [7:0]    alu_data_ip_2;
  logic          alu_parity_ip;
  logic          alu_valid_op = 1'b0;
  logic          alu_ready_op;
  logic [15:0]   alu_data_op = '0;
  logic          alu_err_op = 1'b0;

  alu_req_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (8),
    .SEL_WIDTH      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_data_1    (req_data_1),
    .req_data_2    (req_data_2),
    .req_parity    (req_parity),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .alu_valid_ip  (alu_valid_ip),
    .alu_ready_ip  (alu_ready_ip),
    .alu_sel_ip    (alu_sel_ip),
    .alu_data_ip_1 (alu_data_ip_1),
    .alu_data_ip_2 (alu_data_ip_2),
    .alu_parity_ip (alu_parity_ip),
    .alu_valid_op  (alu_valid_op),
    .alu_ready_op  (alu_ready_op),
    .alu_data_op   (alu_data_op),
    .alu_err_op    (alu_err_op)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  op_t         req_q[NR][$];
  op_t         exp_alu_q[$];
  reply_t      reply_q[$];
  rsp_t        exp_rsp_q[$];
  int unsigned exp_gnt_q[$];
  int unsigned gap_q[$];

  // Event counters written only by the monitor; the driver tracks what it has consumed.
  int unsigned gnt_n[NR] = '{default: 0};
  int unsigned in_hs_n = 0;
  int unsigned out_hs_n = 0;
  int unsigned last_lat = 0;
  int unsigned in_stall = 0;
  int unsigned rsp_stall = 0;
  int unsigned stray_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic send(input int unsigned r, input logic [2:0] sel, input logic [7:0] a,
                      input logic [7:0] b, input logic par, input logic [15:0] rdata,
                      input logic rerr, input int unsigned dly, input logic [15:0] edata,
                      input logic eerr);
    op_t op;
    op = '{sel: sel, d1: a, d2: b, par: par};
    req_q[r].push_back(op);
    exp_gnt_q.push_back(r);
    exp_alu_q.push_back(op);
    reply_q.push_back('{data: rdata, err: rerr, dly: dly});
    exp_rsp_q.push_back('{idx: r, data: edata, err: eerr});
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_rsp_q.delete();
      exp_gnt_q.delete();
      exp_alu_q.delete();
      reply_q.delete();
      for (int i = 0; i < int'(NR); i++) req_q[i].delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_alu_valid_ip", 32'(alu_valid_ip), 32'h0);
    chk("rst_alu_ready_op", 32'(alu_ready_op), 32'h0);
    chk("rst_alu_inputs", 32'({alu_sel_ip, alu_data_ip_1, alu_data_ip_2, alu_parity_ip}), 32'h0);
  endtask

  // Requesters, ALU and response sink: all driven just after the rising edge.
  int unsigned popped[NR] = '{default: 0};
  int unsigned seen_in = 0;
  int unsigned seen_out = 0;
  int unsigned stray_done = 0;
  int unsigned out_cnt = 0;
  logic        out_pend = 1'b0;
  reply_t      cur;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        req_valid    = '0;
        alu_ready_ip = 1'b0;
        alu_valid_op = 1'b0;
        rsp_ready    = '0;
        out_pend     = 1'b0;
        seen_in      = in_hs_n;
        seen_out     = out_hs_n;
        stray_done   = stray_req;
        for (int i = 0; i < int'(NR); i++) popped[i] = gnt_n[i];
      end else begin
        for (int i = 0; i < int'(NR); i++) begin
          if (gnt_n[i] != popped[i]) begin
            popped[i] = gnt_n[i];
            if (req_q[i].size() > 0) req_q[i].delete(0);
          end
          if (req_q[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_sel[i*3 +: 3]   = req_q[i][0].sel;
            req_data_1[i*8 +: 8] = req_q[i][0].d1;
            req_data_2[i*8 +: 8] = req_q[i][0].d2;
            req_parity[i]       = req_q[i][0].par;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
        if (out_hs_n != seen_out) begin
          seen_out     = out_hs_n;
          alu_valid_op = 1'b0;
        end
        if (in_hs_n != seen_in) begin
          seen_in = in_hs_n;
          if (reply_q.size() > 0) begin
            cur      = reply_q.pop_front();
            out_cnt  = cur.dly;
            out_pend = 1'b1;
          end
        end
        if (out_pend) begin
          if (out_cnt == 0) begin
            alu_valid_op = 1'b1;
            alu_data_op  = cur.data;
            alu_err_op   = cur.err;
            out_pend     = 1'b0;
          end else begin
            out_cnt--;
          end
        end else if (stray_req != stray_done && !alu_valid_op) begin
          stray_done   = stray_req;
          alu_valid_op = 1'b1;
          alu_data_op  = 16'hDEAD;
          alu_err_op   = 1'b1;
        end
        if (alu_valid_ip) begin
          if (in_stall > 0) begin
            alu_ready_ip = 1'b0;
            in_stall--;
          end else begin
            alu_ready_ip = 1'b1;
          end
        end else begin
          alu_ready_ip = 1'b0;
        end
        if (rsp_valid != '0) begin
          if (rsp_stall > 0) begin
            rsp_ready = '0;
            rsp_stall--;
          end else begin
            rsp_ready = rsp_valid;
          end
        end else begin
          rsp_ready = '0;
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops scoreboards on handshakes.
  logic          have_prev = 1'b0;
  logic          gnt_seen = 1'b0;
  int unsigned   last_gnt_cyc = 0;
  logic          prev_alu_valid = 1'b0;
  logic          prev_alu_hs = 1'b0;
  op_t           prev_in = '0;
  logic [NR-1:0] prev_rsp_valid = '0;
  logic          prev_rsp_hs = 1'b0;
  logic [16:0]   prev_rsp = '0;

  initial begin
    op_t  cur_in;
    op_t  e_op;
    rsp_t e_rsp;
    int unsigned ridx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_prev = 1'b0;
        gnt_seen  = 1'b0;
      end else begin
        if (req_ready != '0) begin
          chk("grant_onehot", 32'($onehot(req_ready)), 32'h1);
          for (int i = 0; i < int'(NR); i++) begin
            if (req_ready[i]) begin
              gnt_n[i]++;
              chk("grant_valid", 32'(req_valid[i]), 32'h1);
              if (exp_gnt_q.size() == 0) fail_now("unexpected_grant");
              else chk("grant_idx", 32'(i), exp_gnt_q.pop_front());
              if (gnt_seen) gap_q.push_back(cyc - last_gnt_cyc);
              last_gnt_cyc = cyc;
              gnt_seen     = 1'b1;
            end
          end
        end
        cur_in = '{sel: alu_sel_ip, d1: alu_data_ip_1, d2: alu_data_ip_2, par: alu_parity_ip};
        if (have_prev && prev_alu_valid && !prev_alu_hs) begin
          chk("alu_valid_hold", 32'(alu_valid_ip), 32'h1);
          chk("alu_in_stable", 32'(cur_in), 32'(prev_in));
        end
        if (alu_valid_ip && alu_ready_ip) begin
          in_hs_n++;
          if (exp_alu_q.size() == 0) fail_now("unexpected_alu_issue");
          else begin
            e_op = exp_alu_q.pop_front();
            chk("alu_inputs", 32'(cur_in), 32'(e_op));
          end
        end
        if (alu_valid_op) begin
          chk("alu_ready_op", 32'(alu_ready_op), 32'h1);
          if (alu_ready_op) out_hs_n++;
        end
        if (rsp_valid != '0) chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'h1);
        if (have_prev && prev_rsp_valid != '0 && !prev_rsp_hs) begin
          chk("rsp_valid_hold", 32'(rsp_valid), 32'(prev_rsp_valid));
          chk("rsp_stable", 32'({rsp_data, rsp_err}), 32'(prev_rsp));
        end
        if (rsp_valid != '0 && (!have_prev || prev_rsp_valid == '0)) last_lat = cyc - last_gnt_cyc;
        if ((rsp_valid & rsp_ready) != '0) begin
          ridx = 0;
          for (int i = 0; i < int'(NR); i++) if (rsp_valid[i]) ridx = i;
          if (exp_rsp_q.size() == 0) fail_now("unexpected_response");
          else begin
            e_rsp = exp_rsp_q.pop_front();
            chk("rsp_idx", ridx, e_rsp.idx);
            chk("rsp_data", 32'(rsp_data), 32'(e_rsp.data));
            chk("rsp_err", 32'(rsp_err), 32'(e_rsp.err));
          end
        end
        have_prev      = 1'b1;
        prev_alu_valid = alu_valid_ip;
        prev_alu_hs    = alu_valid_ip && alu_ready_ip;
        prev_in        = cur_in;
        prev_rsp_valid = rsp_valid;
        prev_rsp_hs    = (rsp_valid & rsp_ready) != '0;
        prev_rsp       = {rsp_data, rsp_err};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    repeat (3) @(posedge clk);
    #3;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;

    // Contention from reset: 0,1,2,3 then 0 again, 4 cycles apart.
    gap_q.delete();
    send(0, 3'b000, 8'h10, 8'h20, 1'b1, 16'h0030, 1'b0, 0, 16'h0030, 1'b0);
    send(1, 3'b001, 8'h50, 8'h20, 1'b0, 16'h0030, 1'b0, 0, 16'h0030, 1'b0);
    send(2, 3'b010, 8'h0F, 8'h03, 1'b1, 16'h002D, 1'b0, 0, 16'h002D, 1'b0);
    send(3, 3'b011, 8'hAA, 8'h55, 1'b0, 16'h00FF, 1'b0, 0, 16'h00FF, 1'b0);
    send(0, 3'b100, 8'h01, 8'h02, 1'b0, 16'h0003, 1'b0, 0, 16'h0003, 1'b0);
    wait_drain(200);
    chk("gap_count", gap_q.size(), 32'd4);
    for (int i = 0; i < gap_q.size(); i++) chk("grant_gap", gap_q[i], 32'd4);

    // Single request, zero-wait ALU: accept to rsp_valid is 3 cycles.
    send(2, 3'b000, 8'h05, 8'h03, 1'b0, 16'h0008, 1'b0, 0, 16'h0008, 1'b0);
    wait_drain(100);
    chk("single_latency", last_lat, 32'd3);

    // Backpressure on both sides; requester 1 must wait behind 3.
    in_stall  = 5;
    rsp_stall = 3;
    send(3, 3'b101, 8'hC3, 8'h3C, 1'b1, 16'h1234, 1'b0, 0, 16'h1234, 1'b0);
    send(1, 3'b110, 8'h77, 8'h11, 1'b0, 16'h0088, 1'b0, 0, 16'h0088, 1'b0);
    wait_drain(200);
    chk("post_bp_latency", last_lat, 32'd3);

    // ALU error propagated.
    send(0, 3'b111, 8'hFF, 8'hFF, 1'b1, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1);
    wait_drain(100);

    // Stray ALU beat while idle is consumed and does not leak into the next response.
    stray_req++;
    repeat (4) @(posedge clk);
    send(1, 3'b001, 8'h40, 8'h02, 1'b1, 16'h5A5A, 1'b0, 2, 16'h5A5A, 1'b0);
    wait_drain(100);
    chk("delayed_latency", last_lat, 32'd5);

`ifdef ALU_ARB_TIMEOUT_EN
    // Silent ALU: timeout after 8 WAIT cycles, late beat dropped.
    send(2, 3'b010, 8'h21, 8'h12, 1'b0, 16'hBEEF, 1'b0, 15, 16'h0000, 1'b1);
    wait_drain(100);
    chk("timeout_latency", last_lat, 32'd10);
    repeat (15) @(posedge clk);
    send(3, 3'b000, 8'h40, 8'h02, 1'b0, 16'h0042, 1'b0, 0, 16'h0042, 1'b0);
    wait_drain(100);
`endif

    // Reset while in WAIT: asynchronous clear, no response, requester 0 first after.
    n = in_hs_n;
    send(1, 3'b011, 8'h9C, 8'h63, 1'b1, 16'h5555, 1'b0, 40, 16'h5555, 1'b0);
    while (in_hs_n == n && n < in_hs_n + 1 && cyc < 100000) begin
      @(posedge clk);
      if (cyc > 60000) break;
    end
    chk("reset_test_issued", 32'(in_hs_n != n), 32'h1);
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_alu_data", 32'(alu_data_ip_1), 32'h9C);
    rst = 1'b0;
    #1;
    reset_checks();
    exp_rsp_q.delete();
    exp_gnt_q.delete();
    exp_alu_q.delete();
    reply_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    send(0, 3'b000, 8'h11, 8'h22, 1'b0, 16'h0033, 1'b0, 0, 16'h0033, 1'b0);
    send(3, 3'b001, 8'h44, 8'h22, 1'b1, 16'h0022, 1'b0, 0, 16'h0022, 1'b0);
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter sharing one ALU datapath among NUM_REQ requesters. It accepts one request at a time, drives it onto the ALU input handshake, captures the ALU result, and returns it to the originating requester over a per-requester response handshake. It sits between the requesting engines and the ALU, and is the only master of the ALU input interface.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, ALU operand width
- SEL_WIDTH, 3, ALU opcode width
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with ALU_ARB_TIMEOUT_EN)

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_sel  in  NUM_REQ×SEL_WIDTH  opcode per requester
- req_data_1 / req_data_2  in  NUM_REQ×DATA_WIDTH  operands per requester
- req_parity  in  NUM_REQ  parity bit per requester, forwarded unchanged
- rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  2×DATA_WIDTH  shared response data bus
- rsp_err  out  1  shared response error flag
- alu_valid_ip  out  1  / alu_ready_ip  in  1  ALU input handshake
- alu_sel_ip  out  SEL_WIDTH; alu_data_ip_1, alu_data_ip_2  out  DATA_WIDTH; alu_parity_ip  out  1
- alu_valid_op  in  1  / alu_ready_op  out  1  ALU output handshake
- alu_data_op  in  2×DATA_WIDTH; alu_err_op  in  1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, winner g = first valid requester searching from ptr+1 modulo NUM_REQ; req_ready[g]=1 in the same cycle (combinational); sel/data/parity captured into holding registers, g latched; ptr<=g; -> ISSUE. Other req_ready bits stay 0.
- ISSUE: alu_valid_ip=1, ALU inputs driven from holding registers and held stable; on alu_ready_ip -> WAIT.
- WAIT: alu_ready_op=1; on alu_valid_op, capture alu_data_op/alu_err_op -> RESP.
- RESP: rsp_valid[g]=1, rsp_data/rsp_err held; on rsp_ready[g] -> IDLE.
- req_ready=0 in all states except IDLE; only one transaction is ever in flight.
- alu_valid_op while not in WAIT: alu_ready_op=1, beat is consumed and discarded (stale/late response).
- Reset values: FSM=IDLE, ptr=NUM_REQ-1 (requester 0 wins first), all valid/ready outputs 0, rsp_data=0, rsp_err=0, ALU data outputs 0.
- Reset mid-transaction: in-flight transaction abandoned; no response issued.
- rsp_valid for requesters other than g always 0; requester that deasserts req_valid before acceptance is simply not granted.

## Timing
- Accept in cycle T; alu_valid_ip from T+1.
- Zero-wait ALU (ready_ip at T+1, valid_op at T+2): rsp_valid at T+3; minimum accept-to-accept spacing 4 cycles.
- Back-to-back contention: after RESP completes, IDLE grants next requester in the following cycle.
- All outputs except req_ready are registered.

## Configuration
- ALU_ARB_TIMEOUT_EN defined: counter in WAIT counts cycles since entry; when it reaches TIMEOUT_CYCLES without alu_valid_op, -> RESP with rsp_data=0, rsp_err=1. Counter clears on every WAIT entry. A late ALU beat is then discarded under the stale rule.
- Undefined: no counter; WAIT waits indefinitely.

## Structure
- Package alu_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default widths, function for next-pointer wrap.
- Sub-module alu_rr_picker: combinational round-robin selector (req vector + ptr -> one-hot grant + index, any-valid flag).

## Test plan
- Single request: req 2 valid, sel=3'b000, data 8'h05/8'h03, ALU returns 16'h0008 -> req_ready[2] one cycle, rsp_valid[2] with rsp_data=16'h0008, rsp_err=0.
- Contention: all 4 valid continuously from reset -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Backpressure: alu_ready_ip low 5 cycles, rsp_ready low 3 cycles -> ALU inputs and rsp_data stable throughout, no second accept.
- ALU error: alu_err_op=1 with data 16'hFFFF -> rsp_err=1, rsp_data=16'hFFFF to correct requester.
- Timeout (EN defined, TIMEOUT_CYCLES=8): ALU silent -> rsp_err=1, rsp_data=0 after 8 WAIT cycles; late alu_valid_op consumed, next request unaffected.
- Reset asserted in WAIT -> all outputs to reset values asynchronously; after release requester 0 wins first.
